// File: rtl/mips_multicycle_if.sv
// Program-load and status bundle of the multi-cycle MIPS core.
// The core takes the slave side; whoever loads programs and watches status takes the master side.
interface mips_multicycle_if #(
  parameter int unsigned IMEM_DEPTH = 32
);
  localparam int unsigned IAW = $clog2(IMEM_DEPTH);

  logic           imem_we;
  logic [IAW-1:0] imem_waddr;
  logic [31:0]    imem_wdata;
  logic [31:0]    ALUResult;
  logic [31:0]    pc;
  logic           instr_done;
  logic           illegal;

  modport master (
    output imem_we, imem_waddr, imem_wdata,
    input  ALUResult, pc, instr_done, illegal
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata,
    output ALUResult, pc, instr_done, illegal
  );
endinterface

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB share a single ALU.
// imem is written through the load port only while Reset is held low.
module mips_multicycle #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter int unsigned DMEM_DEPTH = 32
) (
  input logic              clk,
  input logic              Reset,
  mips_multicycle_if.slave bus
);
  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000110;
  localparam logic [5:0] OpJ    = 6'b100110;
  localparam logic [5:0] OpAddi = 6'b101000;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;
  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluNor, AluSlt} alu_op_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, mdr_q, alu_out_q;
  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] dmem_q [DMEM_DEPTH];
  logic [31:0] rf_q   [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm;
  logic        is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_addi, is_nop, is_illegal;
  alu_op_e     r_op, alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        taken, instr_done;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm    = {{16{ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    r_op = AluAdd;
    is_r = 1'b0;
    if (opcode == OpR) begin
      is_r = 1'b1;
      case (funct)
        6'b100000: r_op = AluAdd;
        6'b100010: r_op = AluSub;
        6'b100100: r_op = AluAnd;
        6'b100101: r_op = AluOr;
        6'b100111: r_op = AluNor;
        6'b101010: r_op = AluSlt;
        default:   is_r = 1'b0;
      endcase
    end
  end

  assign is_lw      = (opcode == OpLw);
  assign is_sw      = (opcode == OpSw);
  assign is_beq     = (opcode == OpBeq);
  assign is_bne     = (opcode == OpBne);
  assign is_j       = (opcode == OpJ);
  assign is_addi    = (opcode == OpAddi);
  assign is_nop     = (ir_q == 32'h0);
  assign is_illegal = !(is_r | is_lw | is_sw | is_beq | is_bne | is_j | is_addi | is_nop);

  // FETCH borrows the ALU for pc+4; EXEC uses it for the instruction itself.
  always_comb begin
    alu_a  = a_q;
    alu_b  = b_q;
    alu_op = AluAdd;
    if (state_q == StFetch) begin
      alu_a = pc_q;
      alu_b = 32'd4;
    end else if (is_lw | is_sw | is_addi) begin
      alu_b = imm;
    end else if (is_beq | is_bne) begin
      alu_op = AluSub;
    end else if (is_r) begin
      alu_op = r_op;
    end
  end

  always_comb begin
    case (alu_op)
      AluAdd:  alu_y = alu_a + alu_b;
      AluSub:  alu_y = alu_a - alu_b;
      AluAnd:  alu_y = alu_a & alu_b;
      AluOr:   alu_y = alu_a | alu_b;
      AluNor:  alu_y = ~(alu_a | alu_b);
      AluSlt:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  assign taken = (is_beq && (alu_y == 32'h0)) || (is_bne && (alu_y != 32'h0));

  always_comb begin
    state_d    = StFetch;
    instr_done = 1'b0;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (is_lw | is_sw)        state_d = StMem;
        else if (is_r | is_addi) state_d = StWb;
        else                     instr_done = 1'b1;
      end
      StMem: begin
        if (is_lw) state_d = StWb;
        else       instr_done = 1'b1;
      end
      StWb:    instr_done = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mdr_q     <= '0;
      alu_out_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          ir_q <= imem_q[pc_q[IAW+1:2]];
          pc_q <= alu_y;
        end
        StDecode: begin
          a_q <= rf_q[rs];
          b_q <= rf_q[rt];
        end
        StExec: begin
          if (is_r | is_lw | is_sw | is_addi | is_beq | is_bne) alu_out_q <= alu_y;
          if (taken)     pc_q <= pc_q + {imm[29:0], 2'b00};
          else if (is_j) pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        end
        StMem: if (is_lw) mdr_q <= dmem_q[alu_out_q[DAW+1:2]];
        StWb: begin
          if (is_r && rd != 5'd0)                rf_q[rd] <= alu_out_q;
          else if (is_addi && rt != 5'd0)        rf_q[rt] <= alu_out_q;
          else if (is_lw && rt != 5'd0)          rf_q[rt] <= mdr_q;
        end
        default: ;
      endcase
    end
  end

  // Memories keep their contents across reset.
  always_ff @(posedge clk) begin
    if (Reset && state_q == StMem && is_sw) dmem_q[alu_out_q[DAW+1:2]] <= b_q;
  end

  always_ff @(posedge clk) begin
    if (!Reset && bus.imem_we) imem_q[bus.imem_waddr] <= bus.imem_wdata;
  end

  assign bus.ALUResult  = alu_out_q;
  assign bus.pc         = pc_q;
  assign bus.instr_done = instr_done;
  assign bus.illegal    = (state_q == StExec) && is_illegal;
endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: an instruction-level ISA model predicts pc, ALUResult,
// instr_done and illegal for every cycle; literal checks pin the model's results.
module tb_mips_multicycle;
  localparam logic [5:0] ADDI = 6'b101000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000110;
  localparam logic [5:0] FADD = 6'b100000;
  localparam logic [5:0] FOR  = 6'b100101;
  localparam logic [5:0] FNOR = 6'b100111;
  localparam logic [5:0] FSLT = 6'b101010;

  logic clk = 1'b0;
  logic Reset = 1'b0;
  mips_multicycle_if bus ();

  mips_multicycle dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_lat = 0;
  int n_ill_seen = 0;

  logic [31:0] m_imem [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_rf   [32];
  logic [31:0] m_pc, m_alu;
  logic [31:0] prog [$];

  bit          chk_en = 1'b0;
  logic [31:0] exp_pc, exp_alu;
  bit          exp_done, exp_ill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!Reset) cyc = 0;
    else begin
      cyc++;
      if (bus.instr_done) begin
        last_lat = cyc;
        cyc = 0;
      end
    end
    if (bus.illegal) n_ill_seen++;
    if (chk_en) begin
      check("pc", bus.pc, exp_pc);
      check("alu", bus.ALUResult, exp_alu);
      check("done", 32'(bus.instr_done), 32'(exp_done));
      check("illegal", 32'(bus.illegal), 32'(exp_ill));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] f);
    return {6'b000000, rs, rt, rd, 5'b00000, f};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'b100110, t};
  endfunction

  task automatic model_reset();
    m_pc  = '0;
    m_alu = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    exp_pc   = '0;
    exp_alu  = '0;
    exp_done = 1'b0;
    exp_ill  = 1'b0;
  endtask

  // Entered and left at posedge+1; holds Reset low while writing every imem word.
  task automatic load();
    logic [31:0] w;
    chk_en = 1'b0;
    Reset  = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      w = (i < prog.size()) ? prog[i] : 32'h0;
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 5'(i);
      bus.imem_wdata = w;
      m_imem[i]      = w;
      @(posedge clk); #1;
    end
    bus.imem_we = 1'b0;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_alu", bus.ALUResult, 32'h0);
    Reset = 1'b1;
  endtask

  // Executes one instruction at ISA level; abort_cycle>0 pulls Reset during that cycle.
  task automatic run_instr(input int abort_cycle);
    logic [31:0] ir, a, b, imm, pc4, npc, nalu, wval;
    logic [4:0]  wreg;
    bit          wen, dwe, ill;
    int          lat;
    ir   = m_imem[m_pc[6:2]];
    a    = m_rf[ir[25:21]];
    b    = m_rf[ir[20:16]];
    imm  = {{16{ir[15]}}, ir[15:0]};
    pc4  = m_pc + 32'd4;
    npc  = pc4;
    nalu = m_alu;
    lat  = 3;
    ill  = 1'b0;
    wen  = 1'b0;
    dwe  = 1'b0;
    wreg = ir[20:16];
    wval = '0;
    case (ir[31:26])
      6'b000000: if (ir != 32'h0) begin
        lat  = 4;
        wen  = 1'b1;
        wreg = ir[15:11];
        case (ir[5:0])
          FADD:      nalu = a + b;
          6'b100010: nalu = a - b;
          6'b100100: nalu = a & b;
          FOR:       nalu = a | b;
          FNOR:      nalu = ~(a | b);
          FSLT:      nalu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin
            lat = 3;
            wen = 1'b0;
            ill = 1'b1;
          end
        endcase
        wval = nalu;
      end
      LW: begin
        nalu = a + imm;
        lat  = 5;
        wen  = 1'b1;
        wval = m_dmem[nalu[6:2]];
      end
      SW: begin
        nalu = a + imm;
        lat  = 4;
        dwe  = 1'b1;
      end
      BEQ: begin
        nalu = a - b;
        if (a == b) npc = pc4 + (imm << 2);
      end
      BNE: begin
        nalu = a - b;
        if (a != b) npc = pc4 + (imm << 2);
      end
      6'b100110: npc = {pc4[31:28], ir[25:0], 2'b00};
      ADDI: begin
        nalu = a + imm;
        lat  = 4;
        wen  = 1'b1;
        wval = nalu;
      end
      default: ill = 1'b1;
    endcase
    for (int c = 1; c <= lat; c++) begin
      exp_pc   = (c == 1) ? m_pc : pc4;
      exp_alu  = (c <= 3) ? m_alu : nalu;
      exp_done = (c == lat);
      exp_ill  = (c == lat) && ill;
      if (c == abort_cycle) Reset = 1'b0;
      @(posedge clk); #1;
      if (c == abort_cycle) begin
        model_reset();
        return;
      end
    end
    m_pc  = npc;
    m_alu = nalu;
    if (wen && wreg != 5'd0) m_rf[wreg] = wval;
    if (dwe) m_dmem[nalu[6:2]] = b;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_instr(0);
  endtask

  initial begin
    int ill_base;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    for (int i = 0; i < 32; i++) m_dmem[i] = '0;
    @(posedge clk); #1;

    // Straight-line ADDI/ADD
    prog = {32'hA0090005, 32'hA00A0007, 32'h012A8820, enc_r(17, 0, 0, FOR)};
    load();
    run(3);
    check("t1_alu", bus.ALUResult, 32'd12);
    check("t1_pc", bus.pc, 32'd12);
    check("t1_lat", 32'(last_lat), 32'd4);
    run(1);
    check("t1_rf17", bus.ALUResult, 32'd12);

    // Signed SLT both ways, NOR
    prog = {enc_i(ADDI, 0, 9, 16'hFFFF), enc_i(ADDI, 0, 10, 16'h0001),
            enc_r(9, 10, 18, FSLT), enc_r(18, 0, 0, FOR),
            enc_r(10, 9, 18, FSLT), enc_r(18, 0, 0, FOR),
            enc_r(0, 0, 18, FNOR), enc_r(18, 0, 0, FOR)};
    load();
    run(4);
    check("t2_slt_lt", bus.ALUResult, 32'd1);
    run(2);
    check("t2_slt_ge", bus.ALUResult, 32'd0);
    run(2);
    check("t2_nor", bus.ALUResult, 32'hFFFFFFFF);

    // Store then load
    prog = {enc_i(ADDI, 0, 9, 16'h0055), enc_i(SW, 0, 9, 16'h0008),
            enc_i(LW, 0, 11, 16'h0008), enc_r(11, 0, 0, FOR)};
    load();
    run(2);
    check("t3_sw_lat", 32'(last_lat), 32'd4);
    check("t3_sw_addr", bus.ALUResult, 32'd8);
    run(1);
    check("t3_lw_lat", 32'(last_lat), 32'd5);
    run(1);
    check("t3_rf11", bus.ALUResult, 32'h55);

    // Branches and jump
    prog = {enc_i(BEQ, 0, 0, 16'h0001), 32'h0, enc_i(BNE, 0, 0, 16'h0001), enc_j(26'd6),
            32'h0, 32'h0, enc_i(ADDI, 0, 9, 16'h0003), enc_i(BNE, 9, 0, 16'hFFF8)};
    load();
    run(1);
    check("t4_beq_pc", bus.pc, 32'd8);
    check("t4_beq_lat", 32'(last_lat), 32'd3);
    run(1);
    check("t4_bne_nt_pc", bus.pc, 32'd12);
    run(1);
    check("t4_j_pc", bus.pc, 32'd24);
    run(2);
    check("t4_bne_back_pc", bus.pc, 32'd0);
    run(1);

    // $0 hardwired, illegal opcode/funct, NOP
    prog = {enc_i(ADDI, 0, 0, 16'h0009), enc_r(0, 0, 0, FOR), enc_r(0, 0, 9, FADD),
            enc_r(9, 0, 0, FOR), 32'hFC000000, 32'h0000003F, 32'h0};
    load();
    run(1);
    check("t5_addi0_alu", bus.ALUResult, 32'd9);
    run(1);
    check("t5_r0", bus.ALUResult, 32'd0);
    run(2);
    check("t5_rf9", bus.ALUResult, 32'd0);
    ill_base = n_ill_seen;
    run(1);
    check("t5_ill_op", 32'(n_ill_seen - ill_base), 32'd1);
    check("t5_ill_pc", bus.pc, 32'd20);
    run(1);
    check("t5_ill_fn", 32'(n_ill_seen - ill_base), 32'd2);
    run(1);
    check("t5_nop", 32'(n_ill_seen - ill_base), 32'd2);
    check("t5_nop_pc", bus.pc, 32'd28);

    // Reset during ADDI write-back
    prog = {enc_r(9, 0, 0, FOR), enc_i(ADDI, 0, 9, 16'h0005), enc_r(9, 0, 0, FOR)};
    load();
    run(1);
    run_instr(4);
    check("t6_rst_pc", bus.pc, 32'd0);
    check("t6_rst_alu", bus.ALUResult, 32'd0);
    Reset = 1'b1;
    run(1);
    check("t6_rf9_clear", bus.ALUResult, 32'd0);
    run(2);
    check("t6_rf9_after", bus.ALUResult, 32'd5);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle.md
# mips_multicycle

Parametrised multi-cycle successor to the team's single-cycle MIPS datapath, executing the same in-house ISA. Ops: R-type, LW, SW, BEQ, BNE, J, ADDI. It adds several things the single-cycle core lacks:
- a state machine sharing one ALU across FETCH/DECODE/EXEC/MEM/WB
- configurable instruction/data memory depth
- a program-load port
- hardwired $0, signed SLT, NOR and illegal-instruction detection

It sits at top level as the CPU core for directed program tests.

## Interface
- IMEM_DEPTH, 32, instruction words (power of 2); IAW = clog2(IMEM_DEPTH)
- DMEM_DEPTH, 32, data words (power of 2); DAW = clog2(DMEM_DEPTH)
- clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-low
- imem_we  in  1  program-load write strobe, honoured only while Reset==0
- imem_waddr  in  IAW  word address for load
- imem_wdata  in  32  instruction word for load
- ALUResult  out  32  registered ALU output (ALUOut), reset 0
- pc  out  32  current PC, reset 0
- instr_done  out  1  one-cycle pulse in final state of each instruction, reset 0
- illegal  out  1  one-cycle pulse with instr_done on undecodable instruction, reset 0

## Operation
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000110, J=100110, ADDI=101000.
- Functs: ADD=100000, SUB=100010, AND=100100, OR=100101, NOR=100111, SLT=101010 (signed).
- Instruction 0x00000000 is a NOP: no write, no illegal.
- Any other opcode or funct sets illegal and is executed as a NOP.
- States:
  - FETCH: IR <= imem[pc[IAW+1:2]]; pc <= pc+4.
  - DECODE: A <= RF[rs]; B <= RF[rt]; imm = sext(IR[15:0]).
  - EXEC:
    - R: ALUOut <= A op B.
    - LW/SW/ADDI: ALUOut <= A + imm.
    - BEQ/BNE: ALUOut <= A − B; if taken (zero for BEQ, nonzero for BNE), pc <= pc + (imm<<2). Instruction ends.
    - J: pc <= {pc[31:28], IR[25:0], 2'b00}; ALUOut unchanged. Instruction ends.
  - MEM:
    - LW: MDR <= dmem[ALUOut[DAW+1:2]].
    - SW: dmem write of B. SW ends here.
  - WB:
    - R: RF[rd] <= ALUOut.
    - ADDI: RF[rt] <= ALUOut.
    - LW: RF[rt] <= MDR.
- Sequences:
  - R/ADDI: F→D→E→WB
  - LW: F→D→E→M→WB
  - SW: F→D→E→M
  - BEQ/BNE/J: F→D→E
  - NOP/illegal: F→D→E
- After the final state, the next state is FETCH.
- Register $0 reads 0; writes to it are discarded.
- Arithmetic is modulo 2^32.
- Memory address bits above IAW+1/DAW+1 are ignored (wrap); bits [1:0] are ignored.
- PC fetch index wraps modulo IMEM_DEPTH.

## Timing
- Reset==0 at an edge, in any state:
  - state <= FETCH; pc, ALUResult, IR, A, B, MDR and all RF entries <= 0.
  - instr_done = illegal = 0.
  - An in-flight instruction is abandoned with no RF, dmem or pc side effect.
  - dmem and imem are not cleared.
- imem_we while Reset==0 writes imem_wdata at imem_waddr on that edge. Ignored while Reset==1.
- First FETCH is the first edge with Reset==1.
- Latency in cycles:
  - R/ADDI/SW = 4
  - LW = 5
  - branch/jump/NOP/illegal = 3
- instr_done is high during the last state's cycle.
- RF and dmem writes take effect on the closing edge of WB/MEM. The next instruction's DECODE sees them.
- ALUResult updates only on EXEC edges.
- Read-during-write hazards cannot occur; there is no forwarding.

## Test plan
1. Load A0090005, A00A0007, 012A8820 (addi $9,5; addi $10,7; add $17,$9,$10), release Reset → instr_done at cycles 4, 8, 12; RF[17]=12; ALUResult=12; pc=12.
2. addi $9,$0,0xFFFF; addi $10,$0,1; slt $18,$9,$10 → RF[18]=1 (signed −1<1). Swap operands → 0. nor $18,$0,$0 → 0xFFFFFFFF.
3. addi $9,$0,0x55; sw $9,8($0); lw $11,8($0) → RF[11]=0x55; LW instr_done 5 cycles after its FETCH; SW writes no RF.
4. beq $0,$0,+1 at pc 0 → next fetch pc=8. bne $0,$0,+1 → next fetch pc=4. j 0x0000003 → next pc=12. Each takes 3 cycles.
5. addi $0,$0,9 then add $9,$0,$0 → RF[9]=0. Opcode 111111 → illegal pulse, no state change except pc+4.
6. Assert Reset during WB of an ADDI → target register stays 0; pc=0; next instruction fetched from word 0 after release.
